mux4_rr_feeder: RTL and testbench

Four-channel round-robin feeder placed directly upstream of the 4:1 data-select mux. It buffers one word per source channel behind a valid/ready handshake and picks the next occupied channel fairly. It drives the mux `sel` code and the four data lanes, and presents the selected word on a valid/ready output port. It also reports which channel supplied that word.

---
 rtl/mux4_rr_feeder_pkg.sv | 18 +
 rtl/mux4_rr_feeder_rr_pick4.sv | 24 ++
 rtl/mux4_rr_feeder.sv | 145 ++++++++++++++
 tb/tb_mux4_rr_feeder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_feeder_pkg.sv
// Shared constants, FSM state type and the mux select encoding for the
// four-channel round-robin feeder.
package mux4_rr_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // The downstream mux numbers its data inputs in reverse, so channel k
  // is selected by code 3-k.
  function automatic logic [1:0] ch2sel(input logic [1:0] ch);
    return 2'd3 - ch;
  endfunction

endpackage

// File: rtl/mux4_rr_feeder_rr_pick4.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last
// (mod 4) and returns the first requesting channel.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins;
  // offset 4 (last itself) is the default.
  always_comb begin
    any  = |req;
    idx  = last;
    cand = last;
    for (int i = 3; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux4_rr_feeder.sv
// Four-channel round-robin feeder sitting in front of a 4:1 data-select
// mux. One word is held per channel; the FSM grants full channels fairly
// and presents the granted word on a registered valid/ready port.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. valid, once raised, holds its data stable until that edge and
// never depends combinationally on ready. in_ready and out_valid/out_data
// are functions of registers (plus flush for in_ready) only.
module mux4_rr_feeder
  import mux4_rr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             flush,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] lane3,
  output logic [WIDTH-1:0] lane2,
  output logic [WIDTH-1:0] lane1,
  output logic [WIDTH-1:0] lane0,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch
);

  state_e           state_q;
  logic [1:0]       grant_q;
  logic [1:0]       last_q;
  logic [1:0]       sel_q;
  logic [NCH-1:0]   full_q;
  logic [NCH-1:0]   full_d;
  logic [WIDTH-1:0] hold_q [NCH];
  logic [WIDTH-1:0] in_data_a [NCH];

  logic [NCH-1:0]   load;
  logic [NCH-1:0]   grant_mask;
  logic             xfer;
  logic [3:0]       pick_req;
  logic [1:0]       pick_last;
  logic             pick_any;
  logic [1:0]       pick_idx;

  assign in_data_a[0] = in_data0;
  assign in_data_a[1] = in_data1;
  assign in_data_a[2] = in_data2;
  assign in_data_a[3] = in_data3;

  // A granted channel is full, so its refill can only land after the drain.
  assign in_ready   = ~full_q & {NCH{~flush}};
  assign load       = in_valid & in_ready;
  assign grant_mask = 4'b0001 << grant_q;
  assign xfer       = (state_q == SEND) & out_ready & ~flush;

  // In SEND the picker looks for the successor of the current grant.
  assign pick_req  = (state_q == SEND) ? (full_q & ~grant_mask) : full_q;
  assign pick_last = (state_q == SEND) ? grant_q : last_q;

  rr_pick4 u_pick (
    .req  (pick_req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Next full flags: flush wins, otherwise set on load and clear on drain.
  always_comb begin
    full_d = full_q;
    if (flush) begin
      full_d = '0;
    end else begin
      if (xfer) full_d = full_d & ~grant_mask;
      full_d = full_d | load;
    end
  end

  // Full flags.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) full_q <= '0;
    else       full_q <= full_d;
  end

  // Per-channel holding registers; contents survive flush.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < NCH; k++) hold_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) hold_q[k] <= in_data_a[k];
      end
    end
  end

  // Arbitration FSM: grant, round-robin pointer and registered mux select.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      sel_q   <= 2'b11;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            sel_q   <= ch2sel(pick_idx);
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            last_q <= grant_q;
            if (pick_any) begin
              grant_q <= pick_idx;
              sel_q   <= ch2sel(pick_idx);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = hold_q[grant_q];
  assign out_ch    = grant_q;
  assign sel       = sel_q;

  assign lane0 = hold_q[0];
  assign lane1 = hold_q[1];
  assign lane2 = hold_q[2];
  assign lane3 = hold_q[3];

endmodule

// File: tb/tb_mux4_rr_feeder.sv
// Self-checking bench for mux4_rr_feeder: expected {channel, word} pairs are
// queued when stimulus is driven and compared as words leave the output.
module tb_mux4_rr_feeder;

  logic       clk;
  logic       rstb;
  logic       flush;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic [3:0] lane3, lane2, lane1, lane0;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_ch;

  logic [5:0] exp_q[$];
  logic [5:0] sb_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         xfer_cnt = 0;
  int         grant_cnt[4];

  mux4_rr_feeder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .lane3     (lane3),
    .lane2     (lane2),
    .lane1     (lane1),
    .lane0     (lane0),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rstb = 1'b0;
    step();
    rstb = 1'b1;
  endtask

  task automatic load(input logic [3:0] mask, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] d3);
    step();
    in_valid = mask;
    in_data0 = d0;
    in_data1 = d1;
    in_data2 = d2;
    in_data3 = d3;
    step();
    in_valid = 4'h0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (rstb && !flush && out_valid && out_ready) begin
      xfer_cnt = xfer_cnt + 1;
      grant_cnt[out_ch] = grant_cnt[out_ch] + 1;
      if (exp_q.size() == 0) begin
        chk("sb_extra", exp_q.size(), 1);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_word", {out_ch, out_data}, sb_e);
        chk("sb_sel", sel, 2'd3 - sb_e[5:4]);
      end
    end
  end

  initial begin
    rstb      = 1'b0;
    flush     = 1'b0;
    in_valid  = 4'h0;
    in_data0  = 4'h0;
    in_data1  = 4'h0;
    in_data2  = 4'h0;
    in_data3  = 4'h0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) grant_cnt[k] = 0;

    // Reset state.
    #12;
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", sel, 2'b11);
    chk("rst_out_ch", out_ch, 0);
    step();
    rstb = 1'b1;

    // Single word on ch2: two edges from load to out_valid.
    load(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 4'hA);
    chk("lat_ch", out_ch, 2);
    chk("lat_sel", sel, 2'b01);
    step();
    exp_q.push_back({2'd2, 4'hA});
    out_ready = 1'b1;
    wait_drain(10);
    @(negedge clk);
    chk("idle_after_one", out_valid, 0);

    // All four channels, back-to-back from a fresh pointer.
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 4'(k + 1)});
    load(4'hF, 4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", out_valid, 1);
    end
    @(negedge clk);
    chk("b2b_drop", out_valid, 0);
    wait_drain(2);

    // Stall with ch1 and ch3 full.
    step();
    out_ready = 1'b0;
    exp_q.push_back({2'd1, 4'h5});
    exp_q.push_back({2'd3, 4'h7});
    load(4'b1010, 4'h0, 4'h5, 4'h0, 4'h7);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 4'h5);
      chk("stall_ch", out_ch, 1);
      chk("stall_sel", sel, 2'b10);
      chk("stall_rdy1", in_ready[1], 0);
      chk("stall_rdy3", in_ready[3], 0);
    end
    step();
    out_ready = 1'b1;
    wait_drain(10);

    // Fairness with every channel continuously refilled.
    step();
    for (int i = 0; i < 16; i++) exp_q.push_back({2'(i % 4), 4'(8 + (i % 4))});
    for (int k = 0; k < 4; k++) grant_cnt[k] = 0;
    xfer_cnt  = 0;
    in_data0  = 4'h8;
    in_data1  = 4'h9;
    in_data2  = 4'hA;
    in_data3  = 4'hB;
    in_valid  = 4'hF;
    for (int n = 0; n < 200; n++) begin
      step();
      if (xfer_cnt >= 16) break;
    end
    out_ready = 1'b0;
    in_valid  = 4'h0;
    chk("fair_xfers", xfer_cnt, 16);
    for (int k = 0; k < 4; k++) chk("fair_grants", grant_cnt[k], 4);
    chk("fair_queue", exp_q.size(), 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Flush while SEND with out_ready and all in_valid high.
    load(4'b0101, 4'h1, 4'h0, 4'h3, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_flush_valid", out_valid, 1);
    chk("pre_flush_ch", out_ch, 0);
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    in_data0  = 4'hE;
    in_data1  = 4'hE;
    in_data2  = 4'hE;
    in_data3  = 4'hE;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 4'h0);
    step();
    flush     = 1'b0;
    in_valid  = 4'h0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_empty", in_ready, 4'hF);
    chk("flush_lane0", lane0, 4'h1);
    chk("flush_lane1", lane1, 4'h9);
    chk("flush_lane3", lane3, 4'hB);
    exp_q.push_back({2'd0, 4'h2});
    exp_q.push_back({2'd2, 4'h5});
    out_ready = 1'b1;
    load(4'b0101, 4'h2, 4'h0, 4'h5, 4'h0);
    wait_drain(10);

    // Asynchronous reset in the middle of SEND.
    step();
    out_ready = 1'b0;
    load(4'b0010, 4'h0, 4'h6, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_areset_valid", out_valid, 1);
    #2;
    rstb = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_sel", sel, 2'b11);
    chk("areset_in_ready", in_ready, 4'hF);
    chk("areset_ch", out_ch, 0);
    chk("areset_lane1", lane1, 4'h0);
    step();
    rstb = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
